// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern generator.
// Holds the pattern mode encodings, the 640x480@60 default timing constants,
// the counter widths and the colour-bar table (one bit per channel, {R,G,B}).
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_EXT   = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } mode_t;

  localparam int H_CNT_W      = 11;
  localparam int V_CNT_W      = 10;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Colour bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_core.sv
// VGA timing core: pixel-clock divider, h/v scan counters, raw sync/de
// decode and frame bookkeeping.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   pix_ce              one-clk pixel enable (last divider phase)
//   pixel_clk           registered divided clock, rises with each pixel update
//   h_cnt, v_cnt        scan position (stage 0)
//   hsync_raw/vsync_raw sync levels decoded from the counters
//   de_raw              active-video flag decoded from the counters
//   frame_start         1-clk pulse in the cycle the counters wrap to (0,0)
//   frame_cnt           frames since reset (wrapping)
module vga_timing_core import vga_pkg::*; #(
  parameter int   CLK_DIV  = DEF_CLK_DIV,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_ce,
  output logic               pixel_clk,
  output logic [H_CNT_W-1:0] h_cnt,
  output logic [V_CNT_W-1:0] v_cnt,
  output logic               hsync_raw,
  output logic               vsync_raw,
  output logic               de_raw,
  output logic               frame_start,
  output logic [15:0]        frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(H_TOTAL - 1);
  localparam logic [H_CNT_W-1:0] H_ACT    = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] HS_BEG   = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] HS_END   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_ACT    = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] VS_BEG   = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] VS_END   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("vga_timing_core: CLK_DIV must be even and >= 2");
  end
  if (H_TOTAL > (1 << H_CNT_W)) begin : g_bad_h
    $error("vga_timing_core: horizontal total does not fit h_cnt");
  end
  if (V_TOTAL > (1 << V_CNT_W)) begin : g_bad_v
    $error("vga_timing_core: vertical total does not fit v_cnt");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic             frame_wrap;

  assign pix_ce     = (div_cnt == DIV_LAST);
  assign div_next   = pix_ce ? {DIV_W{1'b0}} : div_cnt + DIV_W'(1);
  assign frame_wrap = pix_ce && (h_cnt == H_LAST) && (v_cnt == V_LAST);

  assign hsync_raw  = (h_cnt >= HS_BEG && h_cnt < HS_END) ? H_POL : ~H_POL;
  assign vsync_raw  = (v_cnt >= VS_BEG && v_cnt < VS_END) ? V_POL : ~V_POL;
  assign de_raw     = (h_cnt < H_ACT) && (v_cnt < V_ACT);

  // Divider, scan counters and frame bookkeeping.
  // pixel_clk is derived from the next divider value so it rises on the
  // same edge that advances the counters and the output pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= {DIV_W{1'b0}};
      pixel_clk   <= 1'b0;
      h_cnt       <= {H_CNT_W{1'b0}};
      v_cnt       <= {V_CNT_W{1'b0}};
      frame_start <= 1'b0;
      frame_cnt   <= 16'd0;
    end else begin
      div_cnt     <= div_next;
      pixel_clk   <= (div_next < DIV_HALF);
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (pix_ce) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= {H_CNT_W{1'b0}};
          v_cnt <= (v_cnt == V_LAST) ? {V_CNT_W{1'b0}} : v_cnt + V_CNT_W'(1);
        end else begin
          h_cnt <= h_cnt + H_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA pattern generator with programmable timing.
// Each frame shows one of: external pixels, colour bars, checkerboard or a
// solid colour. The source is chosen by 'mode', captured once per frame.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   mode               0 external, 1 colour bars, 2 checker, 3 solid
//   solid_rgb          colour for solid mode {R,G,B}
//   pix_rgb            external pixel, valid one pixel after pix_req
//   pix_req/pix_x/pix_y external pixel request and its coordinate
//   pixel_clk          divided clock for the DAC
//   vga_sync_h/_v/_de  aligned sync and data-enable pins
//   vga_rgb            pixel colour, zero outside active video
//   frame_start        1-clk pulse when the scan wraps to (0,0)
//   frame_cnt          frames since reset
module vga_pattern_gen import vga_pkg::*; #(
  parameter int   CLK_DIV    = DEF_CLK_DIV,
  parameter int   COLOR_W    = 2,
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FP       = DEF_H_FP,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BP       = DEF_H_BP,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FP       = DEF_V_FP,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BP       = DEF_V_BP,
  parameter logic H_POL      = 1'b0,
  parameter logic V_POL      = 1'b0,
  parameter int   CHECK_LOG2 = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  input  logic [3*COLOR_W-1:0] pix_rgb,
  output logic                 pix_req,
  output logic [H_CNT_W-1:0]   pix_x,
  output logic [V_CNT_W-1:0]   pix_y,
  output logic                 pixel_clk,
  output logic                 vga_sync_h,
  output logic                 vga_sync_v,
  output logic                 vga_de,
  output logic [3*COLOR_W-1:0] vga_rgb,
  output logic                 frame_start,
  output logic [15:0]          frame_cnt
);

  localparam int RGB_W = 3 * COLOR_W;

  if (CHECK_LOG2 >= V_CNT_W) begin : g_bad_check
    $error("vga_pattern_gen: CHECK_LOG2 exceeds the coordinate width");
  end

  logic               pix_ce;
  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic               hsync_raw;
  logic               vsync_raw;
  logic               de_raw;

  vga_timing_core #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .H_POL    (H_POL),
    .V_POL    (V_POL)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .pix_ce      (pix_ce),
    .pixel_clk   (pixel_clk),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .de_raw      (de_raw),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  // Widen a one-bit-per-channel colour to full channel depth.
  function automatic logic [RGB_W-1:0] expand_rgb(input logic [2:0] c);
    return {{COLOR_W{c[2]}}, {COLOR_W{c[1]}}, {COLOR_W{c[0]}}};
  endfunction

  mode_t        frame_mode;
  logic         hs_s1;
  logic         vs_s1;
  logic         de_s1;
  logic [2:0]   bar_idx;
  logic [RGB_W-1:0] pattern_rgb;

  // Bar index = number of bar boundaries at or left of x (constant compares).
  always_comb begin
    bar_idx = 3'd0;
    for (int b = 1; b < 8; b++) begin
      bar_idx = bar_idx + {2'b00, (pix_x >= H_CNT_W'(b * H_ACTIVE / 8))};
    end
  end

  // Pattern source for the stage-1 pixel.
  always_comb begin
    pattern_rgb = {RGB_W{1'b0}};
    case (frame_mode)
      MODE_EXT:   pattern_rgb = pix_rgb;
      MODE_BARS:  pattern_rgb = expand_rgb(bar_color(bar_idx));
      MODE_CHECK: pattern_rgb = (pix_x[CHECK_LOG2] ^ pix_y[CHECK_LOG2]) ?
                                {RGB_W{1'b1}} : {RGB_W{1'b0}};
      MODE_SOLID: pattern_rgb = solid_rgb;
      default:    pattern_rgb = {RGB_W{1'b0}};
    endcase
  end

  // Mode latch and two-stage output pipeline. Mode is captured only while
  // the counters sit on (0,0), so the pixel entering stage 1 on that edge
  // is the first to be rendered with the new source.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_mode <= MODE_BARS;
      pix_req    <= 1'b0;
      pix_x      <= {H_CNT_W{1'b0}};
      pix_y      <= {V_CNT_W{1'b0}};
      hs_s1      <= ~H_POL;
      vs_s1      <= ~V_POL;
      de_s1      <= 1'b0;
      vga_sync_h <= ~H_POL;
      vga_sync_v <= ~V_POL;
      vga_de     <= 1'b0;
      vga_rgb    <= {RGB_W{1'b0}};
    end else begin
      pix_req <= pix_ce && de_raw;
      if (pix_ce) begin
        if (h_cnt == {H_CNT_W{1'b0}} && v_cnt == {V_CNT_W{1'b0}}) begin
          frame_mode <= mode_t'(mode);
        end
        pix_x      <= h_cnt;
        pix_y      <= v_cnt;
        hs_s1      <= hsync_raw;
        vs_s1      <= vsync_raw;
        de_s1      <= de_raw;
        vga_sync_h <= hs_s1;
        vga_sync_v <= vs_s1;
        vga_de     <= de_s1;
        vga_rgb    <= de_s1 ? pattern_rgb : {RGB_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen, using a reduced timing set so
// that several whole frames fit in a short run.
module tb_vga_pattern_gen;

  localparam int CD  = 2;
  localparam int HA  = 64;
  localparam int HFP = 4;
  localparam int HSW = 8;
  localparam int HBP = 4;
  localparam int VA  = 8;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 2;
  localparam int CL  = 2;
  localparam int HT  = HA + HFP + HSW + HBP;   // 80
  localparam int VT  = VA + VFP + VSW + VBP;   // 14
  localparam int FRAME = HT * VT;              // 1120 pixels
  localparam int NREC  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd1;
  logic [5:0]  solid_rgb = 6'h00;
  logic [5:0]  pix_rgb;
  logic        pix_req;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic        pixel_clk;
  logic        vga_sync_h;
  logic        vga_sync_v;
  logic        vga_de;
  logic [5:0]  vga_rgb;
  logic        frame_start;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .CLK_DIV(CD), .COLOR_W(2),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .H_POL(1'b0), .V_POL(1'b0), .CHECK_LOG2(CL)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .solid_rgb(solid_rgb), .pix_rgb(pix_rgb),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pixel_clk(pixel_clk),
    .vga_sync_h(vga_sync_h), .vga_sync_v(vga_sync_v), .vga_de(vga_de),
    .vga_rgb(vga_rgb), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  // External pixel source: a simple function of the requested x.
  function automatic logic [5:0] ext_f(input logic [10:0] x);
    return x[5:0] ^ 6'h2A;
  endfunction

  assign pix_rgb = ext_f(pix_x);

  // Per-frame stimulus plus one hand-computed spot pixel per frame.
  typedef struct {
    logic [1:0] mode;
    logic [5:0] solid;
    int         sx;
    int         sy;
    logic [5:0] srgb;
  } rec_t;

  typedef struct {
    logic       de;
    logic       hs;
    logic       vs;
    logic [5:0] rgb;
    int         x;
    int         y;
    int         f;
  } item_t;

  rec_t  tbl [NREC];
  item_t q [$];
  int    k;
  int    frame_mode;
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (pixel step %0d): got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  function automatic logic [5:0] exp_color(input int m, input int x, input int y, input logic [5:0] s);
    logic [5:0] c;
    case (m)
      0: c = ext_f(11'(x));
      1: begin
        case (x / (HA / 8))
          0:       c = 6'h3F;
          1:       c = 6'h3C;
          2:       c = 6'h0F;
          3:       c = 6'h0C;
          4:       c = 6'h33;
          5:       c = 6'h30;
          6:       c = 6'h03;
          default: c = 6'h00;
        endcase
      end
      2: c = ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 6'h3F : 6'h00;
      default: c = s;
    endcase
    return c;
  endfunction

  // One pixel period of the scan: push the expectation for the pixel now in
  // the counters, pop and compare the one now at the pins.
  task automatic step_pixel();
    item_t it;
    item_t old;
    int x, y, f;
    x = k % HT;
    y = (k / HT) % VT;
    f = k / FRAME;
    if (x == 0 && y == 0) frame_mode = int'(mode);
    it.x  = x;
    it.y  = y;
    it.f  = f;
    it.de = (x < HA) && (y < VA);
    it.hs = !(x >= HA + HFP && x < HA + HFP + HSW);
    it.vs = !(y >= VA + VFP && y < VA + VFP + VSW);
    it.rgb = it.de ? exp_color(frame_mode, x, y, solid_rgb) : 6'h00;
    q.push_back(it);

    chk("frame_start", 32'(frame_start), 32'((x == 0 && y == 0 && k != 0) ? 1 : 0));
    chk("frame_cnt", 32'(frame_cnt), 32'((k / FRAME) & 16'hFFFF));
    chk("pixel_clk_hi", 32'(pixel_clk), 32'((k == 0) ? 0 : 1));
    if (q.size() >= 2) begin
      old = q[q.size() - 2];
      chk("pix_req", 32'(pix_req), 32'(old.de));
      chk("pix_xy", {pix_y, 11'(0), pix_x}, {10'(old.y), 11'(0), 11'(old.x)});
    end else begin
      chk("pix_req_rst", 32'(pix_req), 32'd0);
    end
    if (q.size() == 3) begin
      old = q.pop_front();
      chk("pins", {vga_de, vga_sync_h, vga_sync_v, vga_rgb},
          {old.de, old.hs, old.vs, old.rgb});
      if (old.f < NREC && old.x == tbl[old.f].sx && old.y == tbl[old.f].sy)
        chk("spot_rgb", 32'(vga_rgb), 32'(tbl[old.f].srgb));
    end else begin
      chk("pins_rst", {vga_de, vga_sync_h, vga_sync_v, vga_rgb}, {1'b0, 1'b1, 1'b1, 6'h00});
    end

    // Next frame's mode changes mid-frame (active line); solid only in blanking.
    if (f + 1 < NREC && y == 3 && x == 20) mode = tbl[f + 1].mode;
    if (f + 1 < NREC && y == VA + 1 && x == 10) solid_rgb = tbl[f + 1].solid;

    for (int c = 1; c < CD; c++) begin
      @(posedge clk); #1;
      chk("pixel_clk_lo", 32'(pixel_clk), 32'((c < CD / 2) ? 1 : 0));
      chk("pix_req_pulse", 32'(pix_req), 32'd0);
      chk("frame_start_pulse", 32'(frame_start), 32'd0);
    end
    @(posedge clk); #1;
    k++;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first_lo;
    int first_hi;
    tbl[0] = '{2'd1, 6'h00, 0,  0, 6'h3F};   // bars: white
    tbl[1] = '{2'd2, 6'h00, 4,  0, 6'h3F};   // checker: white square
    tbl[2] = '{2'd3, 6'h2D, 63, 7, 6'h2D};   // solid
    tbl[3] = '{2'd0, 6'h2D, 5,  1, 6'h2F};   // external: 5 ^ 2A
    tbl[4] = '{2'd1, 6'h2D, 15, 2, 6'h3C};   // bars: yellow
    tbl[5] = '{2'd2, 6'h2D, 4,  4, 6'h00};   // checker: black square
    tbl[6] = '{2'd3, 6'h12, 32, 3, 6'h12};   // solid
    tbl[7] = '{2'd0, 6'h12, 63, 7, 6'h15};   // external: 3F ^ 2A
    k = 0;
    frame_mode = 1;

    // Reset held: outputs at their idle values.
    mode = tbl[0].mode;
    solid_rgb = tbl[0].solid;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_hold", {pixel_clk, vga_sync_h, vga_sync_v, vga_de, vga_rgb, frame_cnt},
          {1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 16'h0000});
    end
    rst = 1'b0;

    for (int r = 0; r < NREC; r++) begin
      for (int p = 0; p < FRAME; p++) step_pixel();
    end

    // Mid-frame reset at line 2, pixel 30.
    for (int p = 0; p < 2 * HT + 30; p++) step_pixel();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_pins", {pixel_clk, pix_req, vga_sync_h, vga_sync_v, vga_de, vga_rgb, frame_start},
        {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 1'b0});
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // First hsync after release: counters restart at 0, 2-pixel pin latency.
    first_lo = -1;
    first_hi = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (first_lo < 0 && vga_sync_h == 1'b0) first_lo = i;
      if (first_lo >= 0 && first_hi < 0 && vga_sync_h == 1'b1) first_hi = i;
      if (frame_start !== 1'b0 || frame_cnt !== 16'd0) begin
        k = i;
        chk("post_rst_frame", {15'(0), frame_start, frame_cnt}, 32'd0);
      end
    end
    chk("hsync_start", 32'(first_lo), 32'(CD * (HA + HFP + 2)));
    chk("hsync_width", 32'(first_hi - first_lo), 32'(CD * HSW));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
